// File: rtl/icache.sv
// Direct-mapped instruction cache with 2-word blocks, refilled from the memory
// controller over a ramREN/ramwait handshake; saturating hit/miss counters.
module icache #(
  parameter int SETS  = 16,
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             imemREN,
  input  logic [31:0]      imemaddr,
  output logic             ihit,
  output logic [31:0]      imemload,
  input  logic             flush,
  output logic             ramREN,
  output logic [31:0]      ramaddr,
  input  logic [31:0]      ramload,
  input  logic             ramwait,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt
);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 29 - IDX_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, FILL0, FILL1} state_t;

  state_t           state_q, state_d;
  logic [SETS-1:0]  valid_q, valid_d;
  logic [TAG_W-1:0] tag_q  [SETS];
  logic [31:0]      data_q [SETS][2];
  logic [31:0]      miss_addr_q, miss_addr_d;
  logic             ram_ren_q, ram_ren_d;
  logic [31:0]      ram_addr_q, ram_addr_d;
  logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

  logic [IDX_W-1:0] req_idx, fill_idx;
  logic [TAG_W-1:0] req_tag;
  logic             hit, we_word0, we_word1;
  logic             unused_addr_bits;

  assign req_idx          = imemaddr[2+IDX_W:3];
  assign req_tag          = imemaddr[31:3+IDX_W];
  assign fill_idx         = miss_addr_q[2+IDX_W:3];
  assign unused_addr_bits = ^imemaddr[1:0];

  // Only IDLE answers lookups; during a fill the outputs stay quiet.
  assign hit      = (state_q == IDLE) && imemREN && valid_q[req_idx] &&
                    (tag_q[req_idx] == req_tag);
  assign ihit     = hit;
  assign imemload = hit ? data_q[req_idx][imemaddr[2]] : '0;

  assign ramREN   = ram_ren_q;
  assign ramaddr  = ram_addr_q;
  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;

  always_comb begin
    state_d     = state_q;
    valid_d     = valid_q;
    miss_addr_d = miss_addr_q;
    hit_cnt_d   = hit_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    we_word0    = 1'b0;
    we_word1    = 1'b0;

    case (state_q)
      IDLE: begin
        if (hit) begin
          if (hit_cnt_q != CNT_MAX) hit_cnt_d = hit_cnt_q + CNT_W'(1);
        end else if (imemREN) begin
          miss_addr_d = {imemaddr[31:3], 3'b000};
          if (miss_cnt_q != CNT_MAX) miss_cnt_d = miss_cnt_q + CNT_W'(1);
          state_d = FILL0;
        end
      end
      FILL0: begin
        if (!ramwait) begin
          we_word0 = 1'b1;
          state_d  = FILL1;
        end
      end
      FILL1: begin
        if (!ramwait) begin
          we_word1          = 1'b1;
          valid_d[fill_idx] = 1'b1;
          state_d           = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A flush drops every frame and abandons any fill in flight.
    if (flush) begin
      valid_d = '0;
      if (state_q != IDLE) begin
        state_d  = IDLE;
        we_word0 = 1'b0;
        we_word1 = 1'b0;
      end
    end

    ram_ren_d  = (state_d != IDLE);
    ram_addr_d = '0;
    if (state_d == FILL0)      ram_addr_d = miss_addr_d;
    else if (state_d == FILL1) ram_addr_d = miss_addr_q + 32'd4;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values computed above, independent of statement order.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= IDLE;
      valid_q     <= '0;
      miss_addr_q <= '0;
      ram_ren_q   <= 1'b0;
      ram_addr_q  <= '0;
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      miss_addr_q <= miss_addr_d;
      ram_ren_q   <= ram_ren_d;
      ram_addr_q  <= ram_addr_d;
      hit_cnt_q   <= hit_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
    end
  end

  // NOTE: tag/data arrays carry no reset; valid_q alone guards their contents,
  // which lets them map onto plain RAM.
  always_ff @(posedge CLK) begin
    if (we_word0) data_q[fill_idx][0] <= ramload;
    if (we_word1) begin
      data_q[fill_idx][1] <= ramload;
      tag_q[fill_idx]     <= miss_addr_q[31:3+IDX_W];
    end
  end
endmodule

// File: tb/tb_icache.sv
// Directed self-checking bench for icache: fills, hits, conflicts, stalls,
// flush abort, mid-fill address change and mid-fill reset.
module tb_icache;
  logic        CLK = 1'b0;
  logic        RST;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        flush;
  logic        ramREN;
  logic [31:0] ramaddr;
  logic [31:0] ramload;
  logic        ramwait;
  logic [15:0] hit_cnt;
  logic [15:0] miss_cnt;

  int errors = 0;
  int checks = 0;

  icache #(.SETS(16), .CNT_W(16)) dut (
    .CLK(CLK), .RST(RST), .imemREN(imemREN), .imemaddr(imemaddr),
    .ihit(ihit), .imemload(imemload), .flush(flush), .ramREN(ramREN),
    .ramaddr(ramaddr), .ramload(ramload), .ramwait(ramwait),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  always #5 CLK = ~CLK;

  // Memory image: each word encodes its own address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction

  always_comb ramload = mem_word(ramaddr);

  task automatic apply_reset();
    imemREN = 1'b0; imemaddr = '0; flush = 1'b0; ramwait = 1'b0;
    RST = 1'b1;
    #2;
    RST = 1'b0;
    @(negedge CLK);
  endtask

  // One complete miss with ramwait=0, called with ~1ns after a falling edge.
  task automatic run_miss(input logic [31:0] addr);
    logic [31:0] base;
    base = {addr[31:3], 3'b000};
    imemREN = 1'b1; imemaddr = addr; ramwait = 1'b0;
    #1;
    checks++;
    if (ihit !== 1'b0) begin
      errors++; $display("FAIL miss_compare %h: ihit=%b expected 0", addr, ihit);
    end
    @(negedge CLK); #1;
    checks++;
    if (ramREN !== 1'b1 || ramaddr !== base) begin
      errors++; $display("FAIL fill0 %h: ramREN=%b ramaddr=%h expected 1 %h", addr, ramREN, ramaddr, base);
    end
    @(negedge CLK); #1;
    checks++;
    if (ramREN !== 1'b1 || ramaddr !== base + 32'd4) begin
      errors++; $display("FAIL fill1 %h: ramREN=%b ramaddr=%h expected 1 %h", addr, ramREN, ramaddr, base + 32'd4);
    end
    @(negedge CLK); #1;
    checks++;
    if (ihit !== 1'b1 || imemload !== mem_word(addr) || ramREN !== 1'b0) begin
      errors++; $display("FAIL post_fill_hit %h: ihit=%b imemload=%h ramREN=%b expected 1 %h 0", addr, ihit, imemload, ramREN, mem_word(addr));
    end
  endtask

  task automatic test_reset();
    RST = 1'b1; imemREN = 1'b1; imemaddr = 32'h40; flush = 1'b0; ramwait = 1'b0;
    @(negedge CLK); @(negedge CLK); #1;
    checks++;
    if (ihit !== 1'b0 || imemload !== 32'h0 || ramREN !== 1'b0 || ramaddr !== 32'h0) begin
      errors++; $display("FAIL reset_outputs: ihit=%b imemload=%h ramREN=%b ramaddr=%h expected 0 0 0 0", ihit, imemload, ramREN, ramaddr);
    end
    checks++;
    if (hit_cnt !== 16'h0 || miss_cnt !== 16'h0) begin
      errors++; $display("FAIL reset_counters: hit=%0d miss=%0d expected 0 0", hit_cnt, miss_cnt);
    end
  endtask

  task automatic test_fill_and_hit();
    RST = 1'b0;
    run_miss(32'h40);
    checks++;
    if (miss_cnt !== 16'd1 || hit_cnt !== 16'd0) begin
      errors++; $display("FAIL first_miss_counts: hit=%0d miss=%0d expected 0 1", hit_cnt, miss_cnt);
    end
    @(negedge CLK);
    imemaddr = 32'h44;
    #1;
    checks++;
    if (ihit !== 1'b1 || imemload !== mem_word(32'h44) || ramREN !== 1'b0 || hit_cnt !== 16'd1) begin
      errors++; $display("FAIL hit_word1: ihit=%b imemload=%h ramREN=%b hit=%0d expected 1 %h 0 1", ihit, imemload, ramREN, hit_cnt, mem_word(32'h44));
    end
    @(negedge CLK);
    imemREN = 1'b0;
    #1;
    checks++;
    if (ihit !== 1'b0 || imemload !== 32'h0 || hit_cnt !== 16'd2) begin
      errors++; $display("FAIL idle_no_req: ihit=%b imemload=%h hit=%0d expected 0 0 2", ihit, imemload, hit_cnt);
    end
    @(negedge CLK); #1;
    checks++;
    if (hit_cnt !== 16'd2 || miss_cnt !== 16'd1) begin
      errors++; $display("FAIL no_count_without_req: hit=%0d miss=%0d expected 2 1", hit_cnt, miss_cnt);
    end
  endtask

  task automatic test_conflict();
    apply_reset();
    run_miss(32'h40);
    run_miss(32'hC0);
    run_miss(32'h40);
    checks++;
    if (miss_cnt !== 16'd3 || hit_cnt !== 16'd0) begin
      errors++; $display("FAIL conflict_counts: hit=%0d miss=%0d expected 0 3", hit_cnt, miss_cnt);
    end
  endtask

  task automatic test_stall();
    apply_reset();
    imemREN = 1'b1; imemaddr = 32'h104; ramwait = 1'b1;
    #1;
    checks++;
    if (ihit !== 1'b0) begin
      errors++; $display("FAIL stall_compare: ihit=%b expected 0", ihit);
    end
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < 6; i++) begin
        @(negedge CLK);
        ramwait = (i == 5) ? 1'b0 : 1'b1;
        #1;
        checks++;
        if (ramREN !== 1'b1 || ramaddr !== 32'h100 + 32'(4 * b) || ihit !== 1'b0) begin
          errors++; $display("FAIL stall_beat%0d_cyc%0d: ramREN=%b ramaddr=%h ihit=%b expected 1 %h 0", b, i, ramREN, ramaddr, ihit, 32'h100 + 32'(4 * b));
        end
      end
    end
    @(negedge CLK); #1;
    checks++;
    if (ihit !== 1'b1 || imemload !== mem_word(32'h104) || ramREN !== 1'b0) begin
      errors++; $display("FAIL stall_done: ihit=%b imemload=%h ramREN=%b expected 1 %h 0", ihit, imemload, ramREN, mem_word(32'h104));
    end
  endtask

  task automatic test_flush();
    apply_reset();
    imemREN = 1'b1; imemaddr = 32'h200; ramwait = 1'b0;
    @(negedge CLK); #1;
    checks++;
    if (ramREN !== 1'b1 || ramaddr !== 32'h200) begin
      errors++; $display("FAIL flush_fill0: ramREN=%b ramaddr=%h expected 1 00000200", ramREN, ramaddr);
    end
    @(negedge CLK);
    flush = 1'b1;
    #1;
    checks++;
    if (ramREN !== 1'b1 || ramaddr !== 32'h204) begin
      errors++; $display("FAIL flush_fill1: ramREN=%b ramaddr=%h expected 1 00000204", ramREN, ramaddr);
    end
    @(negedge CLK);
    flush = 1'b0;
    #1;
    checks++;
    if (ramREN !== 1'b0 || ihit !== 1'b0) begin
      errors++; $display("FAIL flush_abort: ramREN=%b ihit=%b expected 0 0", ramREN, ihit);
    end
    @(negedge CLK); #1;
    checks++;
    if (ramREN !== 1'b1 || ramaddr !== 32'h200 || miss_cnt !== 16'd2) begin
      errors++; $display("FAIL flush_rerequest: ramREN=%b ramaddr=%h miss=%0d expected 1 00000200 2", ramREN, ramaddr, miss_cnt);
    end
    @(negedge CLK); @(negedge CLK); #1;
    checks++;
    if (ihit !== 1'b1 || imemload !== mem_word(32'h200)) begin
      errors++; $display("FAIL flush_refill_hit: ihit=%b imemload=%h expected 1 %h", ihit, imemload, mem_word(32'h200));
    end
    flush = 1'b1;
    #1;
    checks++;
    if (ihit !== 1'b1 || imemload !== mem_word(32'h200)) begin
      errors++; $display("FAIL flush_keeps_hit: ihit=%b imemload=%h expected 1 %h", ihit, imemload, mem_word(32'h200));
    end
    @(negedge CLK);
    flush = 1'b0;
    #1;
    checks++;
    if (ihit !== 1'b0 || hit_cnt !== 16'd1) begin
      errors++; $display("FAIL flush_invalidates: ihit=%b hit=%0d expected 0 1", ihit, hit_cnt);
    end
  endtask

  task automatic test_addr_change();
    apply_reset();
    imemREN = 1'b1; imemaddr = 32'h40; ramwait = 1'b1;
    @(negedge CLK);
    imemaddr = 32'h80;
    #1;
    checks++;
    if (ramREN !== 1'b1 || ramaddr !== 32'h40 || ihit !== 1'b0) begin
      errors++; $display("FAIL chg_fill0: ramREN=%b ramaddr=%h ihit=%b expected 1 00000040 0", ramREN, ramaddr, ihit);
    end
    @(negedge CLK);
    ramwait = 1'b0;
    #1;
    checks++;
    if (ramaddr !== 32'h40) begin
      errors++; $display("FAIL chg_fill0_hold: ramaddr=%h expected 00000040", ramaddr);
    end
    @(negedge CLK); #1;
    checks++;
    if (ramaddr !== 32'h44) begin
      errors++; $display("FAIL chg_fill1: ramaddr=%h expected 00000044", ramaddr);
    end
    @(negedge CLK); #1;
    checks++;
    if (ramREN !== 1'b0 || ihit !== 1'b0) begin
      errors++; $display("FAIL chg_new_miss: ramREN=%b ihit=%b expected 0 0", ramREN, ihit);
    end
    @(negedge CLK); #1;
    checks++;
    if (ramREN !== 1'b1 || ramaddr !== 32'h80) begin
      errors++; $display("FAIL chg_fill_new: ramREN=%b ramaddr=%h expected 1 00000080", ramREN, ramaddr);
    end
    @(negedge CLK); @(negedge CLK); #1;
    checks++;
    if (ihit !== 1'b1 || imemload !== mem_word(32'h80)) begin
      errors++; $display("FAIL chg_hit_new: ihit=%b imemload=%h expected 1 %h", ihit, imemload, mem_word(32'h80));
    end
    imemaddr = 32'h40;
    #1;
    checks++;
    if (ihit !== 1'b1 || imemload !== mem_word(32'h40) || miss_cnt !== 16'd2) begin
      errors++; $display("FAIL chg_old_valid: ihit=%b imemload=%h miss=%0d expected 1 %h 2", ihit, imemload, miss_cnt, mem_word(32'h40));
    end
  endtask

  task automatic test_reset_mid_fill();
    apply_reset();
    imemREN = 1'b1; imemaddr = 32'h300; ramwait = 1'b1;
    @(negedge CLK); #1;
    checks++;
    if (ramREN !== 1'b1 || ramaddr !== 32'h300) begin
      errors++; $display("FAIL rst_fill_start: ramREN=%b ramaddr=%h expected 1 00000300", ramREN, ramaddr);
    end
    RST = 1'b1;
    #1;
    checks++;
    if (ramREN !== 1'b0 || ramaddr !== 32'h0 || miss_cnt !== 16'd0) begin
      errors++; $display("FAIL rst_async: ramREN=%b ramaddr=%h miss=%0d expected 0 0 0", ramREN, ramaddr, miss_cnt);
    end
    RST = 1'b0;
    ramwait = 1'b0;
    @(negedge CLK); #1;
    checks++;
    if (ramREN !== 1'b1 || ramaddr !== 32'h300 || miss_cnt !== 16'd1) begin
      errors++; $display("FAIL rst_refill: ramREN=%b ramaddr=%h miss=%0d expected 1 00000300 1", ramREN, ramaddr, miss_cnt);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_fill_and_hit();
    test_conflict();
    test_stall();
    test_flush();
    test_addr_change();
    test_reset_mid_fill();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
